gate_checker: RTL and testbench

//  Self-checking response end of the gate test flow: stimulus side drives a/b into
//  a gate DUT; this block samples a, b and DUT out on each valid strobe, computes
//  the expected value for the selected gate op, and counts vectors and mismatches.
//  It latches the first failure and reports pass/fail after NUM_VEC vectors.

---
 rtl/gate_check_pkg.sv | 16 +
 rtl/gate_ref_model.sv | 21 ++
 rtl/gate_checker.sv | 92 +++++++++
 tb/tb_gate_checker.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// gate_check_pkg: gate op codes and checker FSM state encoding
package gate_check_pkg;
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_BUF  = 3'd7;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational reference result for a bitwise two-input gate op
module gate_ref_model
  import gate_check_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] expected
);
  always_comb begin
    expected = op == OP_AND  ? a & b :
               op == OP_OR   ? a | b :
               op == OP_XOR  ? a ^ b :
               op == OP_NAND ? ~(a & b) :
               op == OP_NOR  ? ~(a | b) :
               op == OP_XNOR ? ~(a ^ b) :
               op == OP_NOT  ? ~a : a;
  end
endmodule

// File: rtl/gate_checker.sv
// gate_checker: compares a gate DUT's output against the reference model per vector,
// counting vectors and mismatches and holding the first failure until the next run
module gate_checker
  import gate_check_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int CNT_W   = 8,
  parameter int NUM_VEC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] out,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);
  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] vec_q, vec_d, err_q, err_d, fidx_q, fidx_d;
  logic [WIDTH-1:0] fexp_q, fexp_d, fgot_q, fgot_d, expected;
  logic             pass_q, pass_d;
  logic             start_ok, accept, mismatch, first_hit, last;
  gate_ref_model #(.WIDTH(WIDTH)) u_ref (
    .op       (op_q),
    .a        (a),
    .b        (b),
    .expected (expected)
  );
  always_comb begin
    start_ok  = start && state_q != S_RUN;
    accept    = valid && state_q == S_RUN;
    mismatch  = expected != out;
    first_hit = accept && mismatch && err_q == '0;
    last      = accept && vec_q == LAST_IDX;
    state_d   = start_ok ? S_RUN : last ? S_DONE : state_q;
    op_d      = start_ok ? op : op_q;
    vec_d     = start_ok ? '0 : accept ? vec_q + 1'b1 : vec_q;
    err_d     = start_ok ? '0 : (accept && mismatch && !(&err_q)) ? err_q + 1'b1 : err_q;
    fidx_d    = start_ok ? '0 : first_hit ? vec_q : fidx_q;
    fexp_d    = start_ok ? '0 : first_hit ? expected : fexp_q;
    fgot_d    = start_ok ? '0 : first_hit ? out : fgot_q;
    // pass must reflect the final vector, so it is derived from the next error count
    pass_d    = start_ok ? 1'b0 : last ? err_d == '0 : pass_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_q  <= '0;
      err_q  <= '0;
      fidx_q <= '0;
      fexp_q <= '0;
      fgot_q <= '0;
      pass_q <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      err_q  <= err_d;
      fidx_q <= fidx_d;
      fexp_q <= fexp_d;
      fgot_q <= fgot_d;
      pass_q <= pass_d;
    end
  end
  assign ready         = state_q == S_RUN;
  assign busy          = state_q == S_RUN;
  assign done          = state_q == S_DONE;
  assign pass          = pass_q;
  assign vec_count     = vec_q;
  assign err_count     = err_q;
  assign first_err_idx = fidx_q;
  assign first_err_exp = fexp_q;
  assign first_err_got = fgot_q;
endmodule

// File: tb/tb_gate_checker.sv
// tb_gate_checker: directed vectors with hand-computed results for gate_checker
module tb_gate_checker;
  logic       clk = 1'b0;
  logic       reset, start, valid;
  logic [2:0] op;
  logic [0:0] a, b, out;
  logic       ready, busy, done, pass, ready6, busy6, done6, pass6;
  logic [7:0] vec_count, err_count, first_err_idx;
  logic [1:0] vec6, err6, fidx6;
  logic [0:0] first_err_exp, first_err_got, fexp6, fgot6;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  gate_checker #(.WIDTH(1), .CNT_W(8), .NUM_VEC(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .valid(valid),
    .a(a), .b(b), .out(out), .ready(ready), .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count), .first_err_idx(first_err_idx),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );
  gate_checker #(.WIDTH(1), .CNT_W(2), .NUM_VEC(3)) u_dut6 (
    .clk(clk), .reset(reset), .start(start), .op(op), .valid(valid),
    .a(a), .b(b), .out(out), .ready(ready6), .busy(busy6), .done(done6), .pass(pass6),
    .vec_count(vec6), .err_count(err6), .first_err_idx(fidx6),
    .first_err_exp(fexp6), .first_err_got(fgot6)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic do_start(input logic [2:0] o);
    start = 1'b1;
    op = o;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic vec(input logic av, input logic bv, input logic ov);
    valid = 1'b1;
    a = av;
    b = bv;
    out = ov;
    @(negedge clk);
    valid = 1'b0;
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; valid = 1'b0; op = 3'd0; a = 1'b0; b = 1'b0; out = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_vec", vec_count, 0);
    chk("rst_err", err_count, 0);
    reset = 1'b0;
    @(negedge clk);
    // AND, all correct
    do_start(3'd0);
    chk("t1_busy", busy, 1);
    chk("t1_ready", ready, 1);
    vec(0, 0, 0); vec(0, 1, 0); vec(1, 0, 0); vec(1, 1, 1);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_vec", vec_count, 4);
    chk("t1_err", err_count, 0);
    chk("t1_busy_off", busy, 0);
    vec(1, 1, 0);
    chk("t5_done_valid_vec", vec_count, 4);
    chk("t5_done_valid_err", err_count, 0);
    // AND, third vector wrong
    do_start(3'd0);
    chk("t2_clr_vec", vec_count, 0);
    chk("t2_clr_pass", pass, 0);
    chk("t2_clr_done", done, 0);
    vec(0, 0, 0); vec(0, 1, 0); vec(1, 0, 1); vec(1, 1, 1);
    chk("t2_err", err_count, 1);
    chk("t2_fidx", first_err_idx, 2);
    chk("t2_fexp", first_err_exp, 0);
    chk("t2_fgot", first_err_got, 1);
    chk("t2_pass", pass, 0);
    chk("t2_done", done, 1);
    // XOR, first and last wrong; start mid-run must not clear
    do_start(3'd2);
    chk("t3_clr_err", err_count, 0);
    chk("t3_clr_fgot", first_err_got, 0);
    vec(0, 0, 1);
    chk("t3_err1", err_count, 1);
    chk("t3_fidx1", first_err_idx, 0);
    do_start(3'd0);
    chk("t5_run_start_vec", vec_count, 1);
    chk("t5_run_start_err", err_count, 1);
    chk("t5_run_start_busy", busy, 1);
    vec(0, 1, 1); vec(1, 0, 1); vec(1, 1, 1);
    chk("t3_err", err_count, 2);
    chk("t3_fidx", first_err_idx, 0);
    chk("t3_fexp", first_err_exp, 0);
    chk("t3_fgot", first_err_got, 1);
    chk("t3_pass", pass, 0);
    chk("t3_done", done, 1);
    // reset mid-run
    do_start(3'd1);
    vec(0, 0, 0); vec(1, 0, 1);
    chk("t4_vec2", vec_count, 2);
    reset = 1'b1;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_vec", vec_count, 0);
    chk("t4_ready", ready, 0);
    @(negedge clk);
    reset = 1'b0;
    vec(1, 1, 1);
    chk("t5_idle_valid_vec", vec_count, 0);
    chk("t5_idle_valid_err", err_count, 0);
    do_start(3'd4);
    vec(0, 0, 1);
    chk("t4_restart_vec", vec_count, 1);
    chk("t4_restart_err", err_count, 0);
    vec(0, 1, 0); vec(1, 0, 0); vec(1, 1, 0);
    chk("t4_nor_pass", pass, 1);
    // start and valid together in DONE: start wins
    start = 1'b1; op = 3'd3; valid = 1'b1; a = 1'b1; b = 1'b1; out = 1'b1;
    @(negedge clk);
    start = 1'b0; valid = 1'b0;
    chk("t5_sv_vec", vec_count, 0);
    chk("t5_sv_err", err_count, 0);
    chk("t5_sv_busy", busy, 1);
    // NAND, then XNOR and BUF, all correct
    vec(0, 0, 1); vec(0, 1, 1); vec(1, 0, 1); vec(1, 1, 0);
    chk("t7_nand_pass", pass, 1);
    do_start(3'd5);
    vec(0, 0, 1); vec(0, 1, 0); vec(1, 0, 0); vec(1, 1, 1);
    chk("t7_xnor_pass", pass, 1);
    chk("t7_xnor_err", err_count, 0);
    do_start(3'd7);
    vec(0, 0, 0); vec(0, 1, 0); vec(1, 0, 1); vec(1, 1, 1);
    chk("t7_buf_pass", pass, 1);
    chk("t7_buf_err", err_count, 0);
    // narrow counters, NOT op with every vector wrong
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    do_start(3'd6);
    vec(0, 0, 0); vec(0, 1, 0); vec(1, 0, 1);
    chk("t6_err", err6, 3);
    chk("t6_vec", vec6, 3);
    chk("t6_done", done6, 1);
    chk("t6_pass", pass6, 0);
    chk("t6_fidx", fidx6, 0);
    chk("t6_fexp", fexp6, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
